// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the fetch PC and the IF/ID pipeline register.
// Selects the next PC from the mispredict redirect, stall, BTB prediction or PC+4, and keeps fetch and redirect statistics.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        btb_hit_i,
    input  logic        btb_mis_hit_i,
    input  logic [31:0] btb_target_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_id_o,
    output logic [31:0] pc_four_id_o,
    output logic [31:0] instr_id_o,
    output logic        pred_taken_id_o,
    output logic        valid_id_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] redirect_cnt_o
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned INSTR_W  = 4;
    localparam logic [XLEN-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_PREDICT,
        SEL_SEQ
    } pc_sel_e;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_id;
    logic [XLEN-1:0] r_pc_four_id;
    logic [XLEN-1:0] r_instr_id;
    logic            r_pred_taken_id;
    logic            r_valid_id;
    logic            r_misalign;
    logic [XLEN-1:0] r_fetch_cnt;
    logic [XLEN-1:0] r_redirect_cnt;

    pc_sel_e         w_sel;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_next_pc;
    logic            w_target_used;
    logic            w_tgt_misaligned;
    logic            w_load_id;
    logic            w_pred_taken;

    // Word-aligned target; low bits only feed the misalign flag.
    assign w_tgt            = {btb_target_i[XLEN-1:2], 2'b00};
    assign w_tgt_misaligned = |btb_target_i[1:0];
    assign w_pc_plus4       = r_pc + XLEN'(INSTR_W);

    // Redirect beats stall, stall beats prediction, prediction beats sequential.
    always_comb begin
        w_sel = SEL_SEQ;
        if (btb_mis_hit_i) begin
            w_sel = SEL_REDIRECT;
        end else if (stall_i) begin
            w_sel = SEL_HOLD;
        end else if (btb_hit_i) begin
            w_sel = SEL_PREDICT;
        end
    end

    always_comb begin
        w_next_pc     = r_pc;
        w_target_used = 1'b0;
        w_load_id     = 1'b0;
        w_pred_taken  = 1'b0;
        case (w_sel)
            SEL_REDIRECT: begin
                w_next_pc     = w_tgt;
                w_target_used = 1'b1;
            end
            SEL_HOLD: begin
                w_next_pc = r_pc;
            end
            SEL_PREDICT: begin
                w_next_pc     = w_tgt;
                w_target_used = 1'b1;
                w_load_id     = 1'b1;
                w_pred_taken  = 1'b1;
            end
            default: begin
                w_next_pc = w_pc_plus4;
                w_load_id = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID register: bubble on redirect, hold on stall, otherwise capture the fetch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc_id         <= '0;
            r_pc_four_id    <= '0;
            r_instr_id      <= NOP_INSTR;
            r_pred_taken_id <= 1'b0;
            r_valid_id      <= 1'b0;
        end else if (w_sel == SEL_REDIRECT) begin
            r_pc_id         <= '0;
            r_pc_four_id    <= '0;
            r_instr_id      <= NOP_INSTR;
            r_pred_taken_id <= 1'b0;
            r_valid_id      <= 1'b0;
        end else if (w_load_id) begin
            r_pc_id         <= r_pc;
            r_pc_four_id    <= w_pc_plus4;
            r_instr_id      <= instr_i;
            r_pred_taken_id <= w_pred_taken;
            r_valid_id      <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_misalign <= 1'b0;
        end else if (w_target_used && w_tgt_misaligned) begin
            r_misalign <= 1'b1;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (w_load_id && (r_fetch_cnt != CNT_MAX)) begin
                r_fetch_cnt <= r_fetch_cnt + XLEN'(1);
            end
            if ((w_sel == SEL_REDIRECT) && (r_redirect_cnt != CNT_MAX)) begin
                r_redirect_cnt <= r_redirect_cnt + XLEN'(1);
            end
        end
    end

    assign pc_o            = r_pc;
    assign pc_id_o         = r_pc_id;
    assign pc_four_id_o    = r_pc_four_id;
    assign instr_id_o      = r_instr_id;
    assign pred_taken_id_o = r_pred_taken_id;
    assign valid_id_o      = r_valid_id;
    assign misalign_o      = r_misalign;
    assign fetch_cnt_o     = r_fetch_cnt;
    assign redirect_cnt_o  = r_redirect_cnt;
    assign flush_o         = btb_mis_hit_i;

endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
- IF stage that owns the program counter and the IF/ID pipeline register.
- Drives the fetch PC to instruction memory and to the BTB lookup port.
- Picks the next PC from the BTB prediction, the BTB mispredict redirect, a hazard stall, or sequential PC+4.
- Registers the fetched instruction and the prediction metadata into ID; provides fetch and redirect statistics counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected into ID on reset and on flush (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- stall_i  in  1  hazard-unit stall: hold PC and IF/ID.
- btb_hit_i  in  1  BTB predicts taken for the current pc_o.
- btb_mis_hit_i  in  1  BTB reports mispredict resolved in MEM; redirect required.
- btb_target_i  in  32  predicted target (hit) or corrected target (mis_hit).
- instr_i  in  32  instruction read combinationally from imem at pc_o.
- pc_o  out  32  current fetch PC (imem address, BTB pc_if).
- pc_id_o  out  32  PC of instruction in ID.
- pc_four_id_o  out  32  pc_id_o + 4.
- instr_id_o  out  32  instruction in ID.
- pred_taken_id_o  out  1  instruction in ID was fetched under a taken prediction.
- valid_id_o  out  1  ID slot holds a real instruction.
- flush_o  out  1  combinational copy of btb_mis_hit_i for the ID/EX and EX/MEM flush.
- misalign_o  out  1  sticky flag: a redirect or predicted target had bits [1:0] != 0.
- fetch_cnt_o  out  32  count of instructions accepted into ID.
- redirect_cnt_o  out  32  count of mispredict redirects.

Behaviour:
- Reset (async, rst_ni=0), all outputs immediate:
  - pc_o=RESET_PC.
  - pc_id_o=0, pc_four_id_o=0, instr_id_o=NOP_INSTR, pred_taken_id_o=0, valid_id_o=0.
  - misalign_o=0, fetch_cnt_o=0, redirect_cnt_o=0.
  - Reset asserted mid-stall or mid-redirect discards all state.
  - First fetch after release is at RESET_PC on the first rising edge with rst_ni=1.
- Target sanitising: tgt = {btb_target_i[31:2],2'b00}. If btb_target_i[1:0]!=0 while the target is used, set misalign_o (sticky until reset).
- Next-PC priority, evaluated each edge:
  1. btb_mis_hit_i=1: pc<=tgt.
     - IF/ID loads the bubble: instr=NOP_INSTR, valid=0, pred_taken=0, pc_id/pc_four_id=0.
     - redirect_cnt increments.
     - Overrides stall_i.
  2. stall_i=1: pc and the whole IF/ID register hold; no counter changes.
  3. btb_hit_i=1: pc<=tgt.
     - IF/ID loads pc_o, pc_o+4, instr_i, pred_taken=1, valid=1.
  4. Otherwise: pc<=pc_o+4.
     - IF/ID loads pc_o, pc_o+4, instr_i, pred_taken=0, valid=1.
- Latency:
  - pc_o changes one edge after the selecting input is sampled.
  - The instruction at pc_o appears on instr_id_o one edge later (single IF/ID stage).
  - After a redirect, the correct-path instruction reaches ID two edges after btb_mis_hit_i is sampled, with one bubble in between.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- fetch_cnt increments on every edge where IF/ID loads with valid=1 (cases 3 and 4).
- Both counters saturate at 32'hFFFF_FFFF and never wrap.
- flush_o is purely combinational (= btb_mis_hit_i) and is also asserted during reset if the input is high.
- btb_hit_i with stall_i=1: stall wins and the hit is re-evaluated next cycle (the BTB sees the same pc_o).
- Simultaneous btb_mis_hit_i and btb_hit_i: mis_hit wins and the hit is ignored.

Test Plan:
- Reset with RESET_PC=0, release, instr_i=0x00500093, no hits, 3 edges -> pc_o 0,4,8,12; instr_id_o=0x00500093 after edge 1; valid_id_o=1; fetch_cnt_o=3.
- pc_o=0x10, btb_hit_i=1, btb_target_i=0x40 -> next pc_o=0x40; pc_id_o=0x10, pc_four_id_o=0x14, pred_taken_id_o=1.
- pc_o=0x44, btb_mis_hit_i=1, target=0x14 -> pc_o=0x14; instr_id_o=0x13, valid_id_o=0; flush_o=1 same cycle; redirect_cnt_o=1; fetch_cnt_o unchanged.
- stall_i=1 for 3 cycles at pc_o=0x20 -> pc_o and IF/ID frozen, counters frozen. Then stall_i=1 together with btb_mis_hit_i=1 (target 0x80) -> pc_o=0x80 and a bubble enters ID.
- btb_hit_i=1, target=0x4E -> pc_o=0x4C, misalign_o=1, and it stays 1 through later normal fetches until reset.
- pc_o=0xFFFFFFFC, no hit -> pc_o=0. Preload fetch_cnt to 0xFFFFFFFF via long run/force -> stays 0xFFFFFFFF. Assert rst_ni low mid-cycle -> all outputs reach reset values without a clock edge.
